ssd_driver: RTL
===============

# ssd_driver

Seven-segment display driver for the board debug path. Consumes the 32-bit debug read value produced by the register file's switch-selected read port, selects its upper or lower 16 bits, and time-multiplexes the four hex digits onto a common-anode 4-digit display. The displayed value is captured once per refresh frame, so all four digits always come from a single sample.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit; legal range ≥1.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `value`  in  32: debug word to display.
- `half_sel`  in  1: 0 shows `value[15:0]`, 1 shows `value[31:16]`.
- `hold`  in  1: 1 freezes the captured value; new frame starts do not reload it.
- `an`  out  4: digit enables, active-low; `an[k]` drives digit k (k=0 is rightmost).
- `seg`  out  7: segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- `dp`  out  1: decimal point, active-low.
- `frame_tick`  out  1: one-cycle pulse at each frame start.

## Operation
- `cnt` counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and `digit` (2 bits) increments mod 4.
- `frame_start` = (cnt==0 && digit==0). It is true in the first cycle after reset.
- On an edge where `frame_start` is true and `hold`=0: `shadow[15:0]` <= the selected half of `value`, and `sel_q` <= `half_sel`. When `hold`=1, `shadow` and `sel_q` keep their values.
- `frame_tick` <= `frame_start`, independent of `hold`.
- Output registers, updated every edge from the current `digit`/`shadow`:
  - `an`: only bit `digit` is low.
  - `seg` <= hex decode of `shadow[4*digit+3 : 4*digit]`.
  - `dp` <= 0 only when `digit`==3 and `sel_q`==1, i.e. upper half is shown; otherwise 1.
- Hex decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Changes to `value` or `half_sel` mid-frame have no visible effect until the next frame start.
- REFRESH_DIV=1: `digit` advances every cycle and a frame is 4 cycles.

## Timing
- Reset values: cnt=0, digit=0, shadow=0, sel_q=0, an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
- Reset asserted mid-operation: every register takes its reset value at the next edge. No partial-frame state survives.
- First edge after `rst` deasserts:
  - an=1110; seg shows nibble 0 of the old shadow, i.e. "0".
  - shadow captures `value`.
  - frame_tick=1.
- Latency:
  - Capture edge to seg reflecting the new shadow: 1 cycle.
  - `digit` change to `an`/`seg` change: 1 cycle. `an` and `seg` always switch on the same edge, so there is no ghosting mismatch.
- Frame period: 4×REFRESH_DIV cycles. `frame_tick` period is identical.
- hold and frame start in the same cycle: the value of `hold` sampled at that edge decides the capture.

## Configuration
- `SSD_BLANK_EN` defined: leading-zero blanking.
  - Digit k (k≥1) is blanked (an[k]=1, seg=1111111) when `shadow[15:4k]`==0.
  - Digit 0 is never blanked.
  - `dp` is forced to 1 whenever digit 3 is blanked.
- Undefined: all four digits are always lit, with leading zeros shown.

## Test plan
- Reset behaviour, REFRESH_DIV=4: hold rst 3 cycles -> an=1111, seg=1111111, dp=1, frame_tick=0; release -> next edge an=1110, frame_tick=1.
- value=32'h1234ABCD, half_sel=0, REFRESH_DIV=4 -> over one frame, an=1110/1101/1011/0111 each for 4 cycles with seg=0100001(d), 1000110(C), 0000011(b), 0001000(A); dp=1 throughout.
- Same value with half_sel=1 -> digits show 4,3,2,1; dp=0 only while an=0111.
- hold=1 after capturing 0x00FF, then value changes to 0x1111 -> display stays 0x00FF for ≥3 frames while frame_tick still pulses every 16 cycles; hold=0 -> next frame shows 0x1111.
- value changed mid-frame (at digit 1) -> remaining digits of the current frame still show the old sample.
- `SSD_BLANK_EN`, value=0x0005 -> only digit 0 is enabled (an toggles between 1110 and 1111); value=0 -> digit 0 shows "0".

Source files
------------

// File: rtl/ssd_driver_if.sv
// Debug-value / seven-segment bus between the value source and ssd_driver.
// The driver uses the slave view; the source/board side uses the master view.
interface ssd_driver_if;
    logic [31:0] value;
    logic        half_sel;
    logic        hold;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output value, half_sel, hold,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  value, half_sel, hold,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/ssd_driver.sv
// Four-digit common-anode hex display driver; one 16-bit sample per refresh frame, an/seg/dp registered (1 cycle after digit change).
// No backpressure: free-running refresh. Optional macro SSD_BLANK_EN enables leading-zero blanking.
module ssd_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic         clk,
    input  logic         rst,
    ssd_driver_if.slave  bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       digit;
    logic [15:0]      shadow;
    logic             sel_q;
    logic [3:0]       anQ;
    logic [6:0]       segQ;
    logic             dpQ;
    logic             frameTickQ;

    logic             frameStart;
    logic             cntWrap;
    logic             digitBlank;
    logic [3:0]       nibble;

    function automatic logic [6:0] hexDecode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign frameStart = (cnt == '0) && (digit == 2'd0);
    assign cntWrap    = (cnt == CNT_LAST);
    assign nibble     = shadow[{digit, 2'b00} +: 4];

`ifdef SSD_BLANK_EN
    // A digit goes dark when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        digitBlank = 1'b0;
        case (digit)
            2'd1:    digitBlank = (shadow[15:4]  == 12'h000);
            2'd2:    digitBlank = (shadow[15:8]  == 8'h00);
            2'd3:    digitBlank = (shadow[15:12] == 4'h0);
            default: digitBlank = 1'b0;
        endcase
    end
`else
    assign digitBlank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            digit      <= 2'd0;
            shadow     <= 16'h0000;
            sel_q      <= 1'b0;
            anQ        <= 4'b1111;
            segQ       <= 7'b1111111;
            dpQ        <= 1'b1;
            frameTickQ <= 1'b0;
        end else begin
            if (cntWrap) begin
                cnt   <= '0;
                digit <= digit + 2'd1;
            end else begin
                cnt   <= cnt + CNT_W'(1);
            end

            // Sample once per frame so all four digits come from one value.
            if (frameStart && !bus.hold) begin
                shadow <= bus.half_sel ? bus.value[31:16] : bus.value[15:0];
                sel_q  <= bus.half_sel;
            end

            frameTickQ <= frameStart;

            // an and seg update on the same edge, so no digit ever shows a neighbour's segments.
            if (digitBlank) begin
                anQ  <= 4'b1111;
                segQ <= 7'b1111111;
                dpQ  <= 1'b1;
            end else begin
                anQ  <= ~(4'b0001 << digit);
                segQ <= hexDecode(nibble);
                dpQ  <= ~((digit == 2'd3) && sel_q);
            end
        end
    end

    assign bus.an         = anQ;
    assign bus.seg        = segQ;
    assign bus.dp         = dpQ;
    assign bus.frame_tick = frameTickQ;
endmodule
